i2s_rx_packer: RTL and testbench



---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_rx_fifo.sv | 60 ++++++
 rtl/i2s_rx_packer.sv | 101 ++++++++++
 tb/tb_i2s_rx_packer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S RX packer: pack-mode encoding and lane-count helper.
package i2s_pkg;

    localparam int I2S_WORD_W = 32;

    typedef enum logic [1:0] {
        PACK_NONE = 2'b00,
        PACK_16   = 2'b01,
        PACK_8    = 2'b10
    } pack_mode_e;

    function automatic logic [2:0] lanes_per_word(input pack_mode_e mode);
        case (mode)
            PACK_16: return 3'd2;
            PACK_8:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy output.
module i2s_rx_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    localparam int LOG_DEPTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     data_o,
    output logic                 valid_o,
    output logic                 full_o,
    output logic [LOG_DEPTH:0]   level_o
);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [LOG_DEPTH:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH:0] rd_ptr_q, rd_ptr_d;
    logic               do_push, do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign full_o  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {LOG_DEPTH{1'b0}}};
    assign valid_o = wr_ptr_q != rd_ptr_q;
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = valid_o ? mem_q[rd_ptr_q[LOG_DEPTH-1:0]] : '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & valid_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[LOG_DEPTH-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/i2s_rx_packer.sv
// I2S RX word packer: masks, packs 2x16/4x8 samples into 32-bit words and buffers them.
// Optional sign extension in unpacked mode is built when I2S_RX_SIGN_EXT_EN is defined.
module i2s_rx_packer
    import i2s_pkg::*;
#(
    parameter int DEPTH     = 4,
    localparam int LOG_DEPTH = $clog2(DEPTH)
) (
    input  logic                  sck_i,
    input  logic                  rst_i,
    input  logic [31:0]           in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [31:0]           out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_clr_i,
    input  logic [1:0]            cfg_pack_mode_i,
    input  logic [4:0]            cfg_wlen_i,
`ifdef I2S_RX_SIGN_EXT_EN
    input  logic                  cfg_sign_ext_i,
`endif
    output logic                  ovf_o,
    output logic [LOG_DEPTH:0]    level_o
);

    pack_mode_e             mode;
    logic [1:0]             lane_q, lane_d;
    logic [I2S_WORD_W-1:0]  pack_q, pack_d;
    logic                   ovf_q, ovf_d;
    logic [I2S_WORD_W-1:0]  mask, sample, placed, word;
    logic                   flush, full, accept, last, push;

    assign flush      = cfg_clr_i | ~cfg_en_i;
    assign in_ready_o = ~full;
    assign accept     = in_valid_i & ~full & ~flush;
    assign ovf_o      = ovf_q;

    always_comb begin
        mode   = (cfg_pack_mode_i == 2'b11) ? PACK_NONE : pack_mode_e'(cfg_pack_mode_i);
        mask   = 32'hFFFF_FFFF >> (5'd31 - cfg_wlen_i);
        sample = in_data_i & mask;
`ifdef I2S_RX_SIGN_EXT_EN
        if (cfg_sign_ext_i && mode == PACK_NONE && in_data_i[cfg_wlen_i])
            sample = in_data_i | ~mask;
`endif
        case (mode)
            PACK_16: placed = {16'b0, sample[15:0]} << {lane_q[0], 4'b0};
            PACK_8:  placed = {24'b0, sample[7:0]} << {lane_q, 3'b0};
            default: placed = sample;
        endcase
        word = pack_q | placed;
        last = {1'b0, lane_q} == (lanes_per_word(mode) - 3'd1);
        push = accept & last;

        lane_d = lane_q;
        pack_d = pack_q;
        ovf_d  = ovf_q;
        if (flush) begin
            lane_d = '0;
            pack_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (in_valid_i && full) ovf_d = 1'b1;
            if (accept) begin
                lane_d = last ? 2'd0 : lane_q + 2'd1;
                pack_d = last ? '0 : word;
            end
        end
    end

    always_ff @(posedge sck_i) begin
        if (rst_i) begin
            lane_q <= '0;
            pack_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            lane_q <= lane_d;
            pack_q <= pack_d;
            ovf_q  <= ovf_d;
        end
    end

    i2s_rx_fifo #(
        .WIDTH (I2S_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sck_i),
        .rst     (rst_i),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (word),
        .pop_i   (out_ready_i),
        .data_o  (out_data_o),
        .valid_o (out_valid_o),
        .full_o  (full),
        .level_o (level_o)
    );

endmodule

// File: tb/tb_i2s_rx_packer.sv
// Directed self-checking bench for i2s_rx_packer (DEPTH=4).
module tb_i2s_rx_packer;

    logic        sck = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        cfg_en;
    logic        cfg_clr;
    logic [1:0]  cfg_pack_mode;
    logic [4:0]  cfg_wlen;
    logic        ovf;
    logic [2:0]  level;
`ifdef I2S_RX_SIGN_EXT_EN
    logic        cfg_sign_ext;
`endif

    int errors = 0;
    int checks = 0;

    always #5 sck = ~sck;

    i2s_rx_packer #(.DEPTH(4)) dut (
        .sck_i           (sck),
        .rst_i           (rst),
        .in_data_i       (in_data),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .out_data_o      (out_data),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .cfg_en_i        (cfg_en),
        .cfg_clr_i       (cfg_clr),
        .cfg_pack_mode_i (cfg_pack_mode),
        .cfg_wlen_i      (cfg_wlen),
`ifdef I2S_RX_SIGN_EXT_EN
        .cfg_sign_ext_i  (cfg_sign_ext),
`endif
        .ovf_o           (ovf),
        .level_o         (level)
    );

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic clr_pulse();
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    endtask

    task automatic test_mode_none();
        cfg_en = 1'b1; cfg_pack_mode = 2'b00; cfg_wlen = 5'd23;
        push(32'hFFABCDEF);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL none_valid got=%0b exp=1", out_valid); end
        checks++; if (out_data !== 32'h00ABCDEF) begin errors++; $display("FAIL none_data got=%h exp=00abcdef", out_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL none_level got=%0d exp=1", level); end
        pop();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL none_pop_level got=%0d exp=0", level); end
        cfg_wlen = 5'd3;
        push(32'h000000FF);
        checks++; if (out_data !== 32'h0000000F) begin errors++; $display("FAIL mask_wlen3 got=%h exp=0000000f", out_data); end
        pop();
        cfg_pack_mode = 2'b11; cfg_wlen = 5'd31;
        push(32'h12345678);
        checks++; if (out_data !== 32'h12345678) begin errors++; $display("FAIL mode11_data got=%h exp=12345678", out_data); end
        pop();
        cfg_pack_mode = 2'b00;
    endtask

`ifdef I2S_RX_SIGN_EXT_EN
    task automatic test_sign_ext();
        cfg_pack_mode = 2'b00; cfg_wlen = 5'd23; cfg_sign_ext = 1'b1;
        push(32'hFFABCDEF);
        checks++; if (out_data !== 32'hFFABCDEF) begin errors++; $display("FAIL sext_neg got=%h exp=ffabcdef", out_data); end
        pop();
        push(32'hFF123456);
        checks++; if (out_data !== 32'h00123456) begin errors++; $display("FAIL sext_pos got=%h exp=00123456", out_data); end
        pop();
        cfg_pack_mode = 2'b01; cfg_wlen = 5'd15;
        push(32'h0000F111); push(32'h00008222);
        checks++; if (out_data !== 32'h8222F111) begin errors++; $display("FAIL sext_packed got=%h exp=8222f111", out_data); end
        pop();
        cfg_sign_ext = 1'b0; cfg_pack_mode = 2'b00;
    endtask
`endif

    task automatic test_pack16();
        cfg_pack_mode = 2'b01; cfg_wlen = 5'd15;
        push(32'hFFFF1111);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL p16_half_valid got=%0b exp=0", out_valid); end
        push(32'h00002222);
        checks++; if (out_data !== 32'h22221111) begin errors++; $display("FAIL p16_data got=%h exp=22221111", out_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL p16_level got=%0d exp=1", level); end
        pop();
    endtask

    task automatic test_pack8();
        cfg_pack_mode = 2'b10; cfg_wlen = 5'd7;
        push(32'h01); push(32'h02); push(32'h03);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL p8_partial_valid got=%0b exp=0", out_valid); end
        push(32'h04);
        checks++; if (out_data !== 32'h04030201) begin errors++; $display("FAIL p8_data got=%h exp=04030201", out_data); end
        push(32'h05);
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL p8_fifth_level got=%0d exp=1", level); end
        clr_pulse();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL p8_clr_level got=%0d exp=0", level); end
        cfg_pack_mode = 2'b00;
    endtask

    task automatic test_overflow();
        cfg_pack_mode = 2'b00; cfg_wlen = 5'd31; out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(32'(i));
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got=%0b exp=0", in_ready); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", ovf); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_data !== 32'(i)) begin errors++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, out_data, 32'(i)); end
            pop();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%0b exp=0", out_valid); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", ovf); end
    endtask

    task automatic test_clear();
        push(32'hC0); push(32'hC1);
        clr_pulse();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL clr_level got=%0d exp=0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got=%0b exp=0", out_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%0b exp=0", ovf); end
    endtask

    task automatic test_back_to_back();
        push(32'hA); push(32'hB);
        in_valid = 1'b1; in_data = 32'hC; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_level got=%0d exp=2", level); end
        checks++; if (out_data !== 32'hB) begin errors++; $display("FAIL b2b_head1 got=%h exp=b", out_data); end
        pop();
        checks++; if (out_data !== 32'hC) begin errors++; $display("FAIL b2b_head2 got=%h exp=c", out_data); end
        pop();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", level); end
    endtask

    task automatic test_flush_partial();
        cfg_pack_mode = 2'b01; cfg_wlen = 5'd15;
        push(32'h1234);
        cfg_en = 1'b0; in_valid = 1'b1; in_data = 32'h7777;
        tick();
        cfg_en = 1'b1; in_valid = 1'b0;
        push(32'hAAAA); push(32'hBBBB);
        checks++; if (out_data !== 32'hBBBBAAAA) begin errors++; $display("FAIL en_flush_data got=%h exp=bbbbaaaa", out_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL en_flush_level got=%0d exp=1", level); end
        pop();
        push(32'h5555);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push(32'hAAAA); push(32'hBBBB);
        checks++; if (out_data !== 32'hBBBBAAAA) begin errors++; $display("FAIL rst_flush_data got=%h exp=bbbbaaaa", out_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL rst_flush_level got=%0d exp=1", level); end
        pop();
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_en = 1'b0; cfg_clr = 1'b0; cfg_pack_mode = 2'b00; cfg_wlen = 5'd31;
`ifdef I2S_RX_SIGN_EXT_EN
        cfg_sign_ext = 1'b0;
`endif
        test_reset();
        test_mode_none();
`ifdef I2S_RX_SIGN_EXT_EN
        test_sign_ext();
`endif
        test_pack16();
        test_pack8();
        test_overflow();
        test_clear();
        test_back_to_back();
        test_flush_partial();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
